bus_select_reg: RTL and testbench
=================================

Name: bus_select_reg

Overview:
- Parametrised successor of the combinational datapath bus multiplexer.
- N_SRC sources of WIDTH bits drive one shared bus. Each source has a one-hot drive-enable strobe (RxOut/PCout/MDRout style).
- The block encodes the strobes, selects the source, and registers the bus value.
- It detects multi-driver contention with a sticky fault FSM and a saturating contention counter, for the control-unit debug path.

Parameters:
- WIDTH, 32, bus/source data width in bits.
- N_SRC, 24, number of bus sources (2..64); source i occupies src_data[i*WIDTH +: WIDTH].
- CNT_W, 8, width of the saturating contention counter.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous, active-high reset.
- src_data  in  N_SRC*WIDTH  packed source values; source 0 in the LSBs.
- drv_en  in  N_SRC  one-hot drive-enable strobes.
- fault_clr  in  1  synchronous pulse; leaves FAULT and zeroes the counter.
- bus_out  out  WIDTH  registered bus value.
- bus_valid  out  1  high when bus_out was loaded from exactly one driver.
- bus_sel  out  $clog2(N_SRC)  registered encoded index of the last driver.
- contention  out  1  sticky; high while the FSM is in FAULT.
- cont_cnt  out  CNT_W  saturating count of contention cycles.

Behaviour:
- Reset (clr=1, async):
  - bus_out=0, bus_valid=0, bus_sel=0, contention=0, cont_cnt=0.
  - FSM = IDLE.
- Latency: 1 cycle. drv_en/src_data sampled at edge k appear on bus_out/bus_valid/bus_sel after edge k.
- Encoding:
  - n_act = popcount(drv_en).
  - sel = index of the lowest set bit (priority to the lowest index).
- Per-edge update by n_act:
  - n_act==0: bus_out=0, bus_valid=0, bus_sel holds.
  - n_act==1: bus_out=src_data[sel], bus_valid=1, bus_sel=sel.
  - n_act>=2: bus_out=src_data[sel] (lowest index wins), bus_valid=0, bus_sel=sel, cont_cnt increments.
- cont_cnt saturates at 2^CNT_W-1 and never wraps.
- FSM states: IDLE, DRIVE, FAULT.
  - IDLE -> DRIVE when n_act==1.
  - IDLE/DRIVE -> FAULT when n_act>=2.
  - DRIVE -> IDLE when n_act==0.
  - DRIVE stays DRIVE when n_act==1.
  - FAULT holds regardless of drv_en until fault_clr=1.
  - FAULT + fault_clr: go to IDLE (n_act==0) or DRIVE (n_act==1); cont_cnt=0.
  - If n_act>=2 in the same cycle as fault_clr, stay in FAULT and set cont_cnt=1. The new event wins over the clear.
- contention = (state==FAULT), registered.
- In FAULT the bus keeps updating per the n_act rules. Data flow is never blocked; fault is observation only.
- fault_clr outside FAULT: zeroes cont_cnt; state unaffected.
- N_SRC not a power of two: bus_sel never exceeds N_SRC-1.
- clr asserted mid-transfer: all outputs return to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: BUS_SELECT_HOLD_EN.
- Defined: when n_act==0, bus_out holds its previous value instead of clearing to 0. bus_valid still drops to 0. Models a bus-keeper.
- Undefined: n_act==0 drives bus_out=0, matching the default case of the legacy combinational mux.

Decomposition:
- Shared package (cpu_bus_pkg):
  - FSM state typedef (IDLE/DRIVE/FAULT).
  - Source-index constants for the standard datapath map: R0..R15=0..15, HI=16, LO=17, ZHI=18, ZLO=19, PC=20, MDR=21, INPORT=22, CSIGN=23.
  - Default WIDTH and N_SRC.
- One sub-module: onehot_prio_enc (parameter N; inputs onehot; outputs idx, any, multi).
  - Purely combinational.
  - Reused by the write-enable decoding paths.

Test Plan:
- Reset: clr=1 mid-stream with bus_out=0xDEADBEEF -> all outputs 0 before the next edge; FSM IDLE.
- Single driver: drv_en=1<<20 (PC), PC=0x00000104 -> next cycle bus_out=0x104, bus_valid=1, bus_sel=20, contention=0.
- Contention: drv_en has bits 3 and 21 set for 3 cycles, r3=0x11 -> bus_out=0x11, bus_valid=0, bus_sel=3, contention=1, cont_cnt=3. Then drv_en=0 -> contention stays 1. Then fault_clr pulse -> contention=0, cont_cnt=0.
- Clear collides with contention: fault_clr=1 with drv_en bits 0 and 1 set -> contention stays 1, cont_cnt=1.
- Saturation: CNT_W=4, 20 contention cycles -> cont_cnt=15, no wrap.
- No driver: drv_en=0 after bus_out=0x55 -> bus_out=0 (macro undefined) or 0x55 (BUS_SELECT_HOLD_EN); bus_valid=0 in both cases; bus_sel holds.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the datapath bus: bus FSM states, the standard
// source map and default bus geometry.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FAULT = 2'd2
    } bus_state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N_SRC = 24;

    // Drive-enable bit positions of the standard datapath sources
    localparam int SRC_R0     = 0;
    localparam int SRC_R15    = 15;
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHI    = 18;
    localparam int SRC_ZLO    = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int SRC_CSIGN  = 23;

    function automatic int src_reg(input int n);
        return SRC_R0 + n;
    endfunction

endpackage

// File: rtl/onehot_prio_enc.sv
// Combinational priority encoder for nominally one-hot strobes: lowest set bit
// wins, and 'multi' flags more than one active strobe.
module onehot_prio_enc #(
    parameter int N     = 24,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    // Scanning downwards lets the lowest index overwrite any higher match
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any   = |onehot;
    assign multi = |(onehot & (onehot - N'(1)));

endmodule

// File: rtl/bus_select_reg.sv
// Registered shared-bus multiplexer with contention detection (sticky FAULT
// state plus saturating counter). Define BUS_SELECT_HOLD_EN for bus-keeper behaviour.
module bus_select_reg
    import cpu_bus_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_SRC = DEF_N_SRC,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [N_SRC*WIDTH-1:0]     src_data,
    input  logic [N_SRC-1:0]           drv_en,
    input  logic                       fault_clr,
    output logic [WIDTH-1:0]           bus_out,
    output logic                       bus_valid,
    output logic [$clog2(N_SRC)-1:0]   bus_sel,
    output logic                       contention,
    output logic [CNT_W-1:0]           cont_cnt
);

    localparam int SEL_W = $clog2(N_SRC);

    logic [SEL_W-1:0] enc_idx;
    logic             enc_any;
    logic             enc_multi;
    logic [WIDTH-1:0] sel_data;
    logic [CNT_W-1:0] cnt_d;
    bus_state_t       state_q;
    bus_state_t       state_d;

    onehot_prio_enc #(
        .N     (N_SRC),
        .IDX_W (SEL_W)
    ) u_enc (
        .onehot (drv_en),
        .idx    (enc_idx),
        .any    (enc_any),
        .multi  (enc_multi)
    );

    // Encoder index is always below N_SRC, so unused index codes select nothing
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (SEL_W'(i) == enc_idx) begin
                sel_data = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bus_out   <= '0;
            bus_valid <= 1'b0;
            bus_sel   <= '0;
        end else begin
            bus_valid <= enc_any && !enc_multi;
            if (enc_any) begin
                bus_out <= sel_data;
                bus_sel <= enc_idx;
            end else begin
`ifdef BUS_SELECT_HOLD_EN
                bus_out <= bus_out;
`else
                bus_out <= '0;
`endif
            end
        end
    end

    // A contention event in the same cycle as a clear restarts the count at 1
    always_comb begin
        cnt_d = cont_cnt;
        if (enc_multi) begin
            if (fault_clr) begin
                cnt_d = CNT_W'(1);
            end else if (cont_cnt != {CNT_W{1'b1}}) begin
                cnt_d = cont_cnt + CNT_W'(1);
            end
        end else if (fault_clr) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enc_multi) begin
                    state_d = FAULT;
                end else if (enc_any) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (enc_multi) begin
                    state_d = FAULT;
                end else if (!enc_any) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                if (fault_clr && !enc_multi) begin
                    state_d = enc_any ? DRIVE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            cont_cnt <= '0;
        end else begin
            state_q  <= state_d;
            cont_cnt <= cnt_d;
        end
    end

    assign contention = (state_q == FAULT);

endmodule

// File: tb/tb_bus_select_reg.sv
// Self-checking bench for bus_select_reg: directed vector table, multi-cycle
// corner sequences and randomized traffic against a behavioural model.
module tb_bus_select_reg;
    import cpu_bus_pkg::*;

    localparam int W = 32;
    localparam int N = 24;

`ifdef BUS_SELECT_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] drv;
        logic         fclr;
        logic         idle;
        logic [W-1:0] bus;
        logic         valid;
        logic [4:0]   sel;
        logic         cont;
        logic [7:0]   cnt;
    } vec_t;

    logic             clk = 1'b0;
    logic             clr;
    logic [N*W-1:0]   src_data;
    logic [N-1:0]     drv_en;
    logic             fault_clr;
    logic [W-1:0]     bus_out,   bus_out_s;
    logic             bus_valid, bus_valid_s;
    logic [4:0]       bus_sel,   bus_sel_s;
    logic             contention, contention_s;
    logic [7:0]       cont_cnt;
    logic [3:0]       cont_cnt_s;
    logic [W-1:0]     src [N];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [W-1:0] m_bus;
    logic         m_valid;
    int           m_sel;
    logic         m_fault;
    int           m_cnt8;
    int           m_cnt4;

    vec_t vecs [18];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            src_data[i*W +: W] = src[i];
        end
    end

    bus_select_reg #(.WIDTH(W), .N_SRC(N), .CNT_W(8)) dut (
        .clk        (clk),
        .clr        (clr),
        .src_data   (src_data),
        .drv_en     (drv_en),
        .fault_clr  (fault_clr),
        .bus_out    (bus_out),
        .bus_valid  (bus_valid),
        .bus_sel    (bus_sel),
        .contention (contention),
        .cont_cnt   (cont_cnt)
    );

    bus_select_reg #(.WIDTH(W), .N_SRC(N), .CNT_W(4)) dut_small (
        .clk        (clk),
        .clr        (clr),
        .src_data   (src_data),
        .drv_en     (drv_en),
        .fault_clr  (fault_clr),
        .bus_out    (bus_out_s),
        .bus_valid  (bus_valid_s),
        .bus_sel    (bus_sel_s),
        .contention (contention_s),
        .cont_cnt   (cont_cnt_s)
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_bus   = '0;
        m_valid = 1'b0;
        m_sel   = 0;
        m_fault = 1'b0;
        m_cnt8  = 0;
        m_cnt4  = 0;
    endtask

    // Applies the bus rules to the values sampled at one clock edge
    task automatic model_step(input logic [N-1:0] d, input logic f);
        int n;
        int lo;
        n  = $countones(d);
        lo = -1;
        for (int i = 0; i < N; i++) begin
            if (d[i] && lo < 0) lo = i;
        end
        if (n == 0) begin
            m_valid = 1'b0;
            if (!HOLD) m_bus = '0;
        end else begin
            m_bus   = src[lo];
            m_valid = (n == 1);
            m_sel   = lo;
        end
        if (n >= 2) begin
            m_cnt8  = f ? 1 : ((m_cnt8 < 255) ? m_cnt8 + 1 : 255);
            m_cnt4  = f ? 1 : ((m_cnt4 < 15) ? m_cnt4 + 1 : 15);
            m_fault = 1'b1;
        end else if (f) begin
            m_cnt8  = 0;
            m_cnt4  = 0;
            m_fault = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input logic [N-1:0] d, input logic f);
        drv_en    = d;
        fault_clr = f;
        @(posedge clk);
        model_step(d, f);
        #1;
    endtask

    task automatic check_model(input string tag);
        check_output({tag, ".bus_out"},    64'(bus_out),    64'(m_bus));
        check_output({tag, ".bus_valid"},  64'(bus_valid),  64'(m_valid));
        check_output({tag, ".bus_sel"},    64'(bus_sel),    64'(m_sel));
        check_output({tag, ".contention"}, 64'(contention), 64'(m_fault));
        check_output({tag, ".cont_cnt"},   64'(cont_cnt),   64'(m_cnt8));
        check_output({tag, ".cont_cnt4"},  64'(cont_cnt_s), 64'(m_cnt4));
    endtask

    initial begin
        logic [W-1:0] prev_exp;
        logic [W-1:0] exp_bus;
        logic [N-1:0] d;
        int           a;
        int           b;

        for (int i = 0; i < N; i++) src[i] = 32'hA000_0000 | 32'(i);
        src[SRC_PC]     = 32'h0000_0104;
        src[src_reg(3)] = 32'h0000_0011;

        //                drv                               fclr  idle  bus            v     sel    cont  cnt
        vecs[0]  = '{24'h0,                               1'b0, 1'b1, 32'h0,         1'b0, 5'd0,  1'b0, 8'd0};
        vecs[1]  = '{24'(1) << SRC_PC,                    1'b0, 1'b0, 32'h104,       1'b1, 5'd20, 1'b0, 8'd0};
        vecs[2]  = '{24'(1) << SRC_PC,                    1'b0, 1'b0, 32'h104,       1'b1, 5'd20, 1'b0, 8'd0};
        vecs[3]  = '{(24'(1) << 3) | (24'(1) << SRC_MDR), 1'b0, 1'b0, 32'h11,        1'b0, 5'd3,  1'b1, 8'd1};
        vecs[4]  = '{(24'(1) << 3) | (24'(1) << SRC_MDR), 1'b0, 1'b0, 32'h11,        1'b0, 5'd3,  1'b1, 8'd2};
        vecs[5]  = '{(24'(1) << 3) | (24'(1) << SRC_MDR), 1'b0, 1'b0, 32'h11,        1'b0, 5'd3,  1'b1, 8'd3};
        vecs[6]  = '{24'h0,                               1'b0, 1'b1, 32'h0,         1'b0, 5'd3,  1'b1, 8'd3};
        vecs[7]  = '{24'h0,                               1'b1, 1'b1, 32'h0,         1'b0, 5'd3,  1'b0, 8'd0};
        vecs[8]  = '{24'(1) << 7,                         1'b0, 1'b0, 32'hA000_0007, 1'b1, 5'd7,  1'b0, 8'd0};
        vecs[9]  = '{24'h0,                               1'b0, 1'b1, 32'h0,         1'b0, 5'd7,  1'b0, 8'd0};
        vecs[10] = '{24'h3,                               1'b0, 1'b0, 32'hA000_0000, 1'b0, 5'd0,  1'b1, 8'd1};
        vecs[11] = '{24'h3,                               1'b1, 1'b0, 32'hA000_0000, 1'b0, 5'd0,  1'b1, 8'd1};
        vecs[12] = '{24'h2,                               1'b1, 1'b0, 32'hA000_0001, 1'b1, 5'd1,  1'b0, 8'd0};
        vecs[13] = '{24'(1) << SRC_CSIGN,                 1'b0, 1'b0, 32'hA000_0017, 1'b1, 5'd23, 1'b0, 8'd0};
        vecs[14] = '{24'h3 << SRC_INPORT,                 1'b0, 1'b0, 32'hA000_0016, 1'b0, 5'd22, 1'b1, 8'd1};
        vecs[15] = '{24'(1) << 5,                         1'b0, 1'b0, 32'hA000_0005, 1'b1, 5'd5,  1'b1, 8'd1};
        vecs[16] = '{24'(1) << 5,                         1'b1, 1'b0, 32'hA000_0005, 1'b1, 5'd5,  1'b0, 8'd0};
        vecs[17] = '{24'h0,                               1'b1, 1'b1, 32'h0,         1'b0, 5'd5,  1'b0, 8'd0};

        clr       = 1'b1;
        drv_en    = '0;
        fault_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_output("rst.bus_out",    64'(bus_out),    64'h0);
        check_output("rst.bus_valid",  64'(bus_valid),  64'h0);
        check_output("rst.bus_sel",    64'(bus_sel),    64'h0);
        check_output("rst.contention", 64'(contention), 64'h0);
        check_output("rst.cont_cnt",   64'(cont_cnt),   64'h0);
        clr = 1'b0;

        prev_exp = '0;
        for (int v = 0; v < 18; v++) begin
            apply_stimulus(vecs[v].drv, vecs[v].fclr);
            exp_bus  = vecs[v].idle ? (HOLD ? prev_exp : '0) : vecs[v].bus;
            prev_exp = exp_bus;
            check_output($sformatf("vec%0d.bus_out", v),    64'(bus_out),    64'(exp_bus));
            check_output($sformatf("vec%0d.bus_valid", v),  64'(bus_valid),  64'(vecs[v].valid));
            check_output($sformatf("vec%0d.bus_sel", v),    64'(bus_sel),    64'(vecs[v].sel));
            check_output($sformatf("vec%0d.contention", v), 64'(contention), 64'(vecs[v].cont));
            check_output($sformatf("vec%0d.cont_cnt", v),   64'(cont_cnt),   64'(vecs[v].cnt));
        end

        // Saturation of the 4-bit counter while the 8-bit one keeps counting
        for (int c = 1; c <= 20; c++) begin
            apply_stimulus(24'h3, 1'b0);
            if (c == 16) check_output("sat16.cont_cnt4", 64'(cont_cnt_s), 64'd15);
        end
        check_output("sat.cont_cnt4",   64'(cont_cnt_s),   64'd15);
        check_output("sat.cont_cnt",    64'(cont_cnt),     64'd20);
        check_output("sat.contention4", 64'(contention_s), 64'd1);
        apply_stimulus(24'h0, 1'b1);
        check_output("satclr.cont_cnt4", 64'(cont_cnt_s), 64'd0);
        check_output("satclr.cont_cnt",  64'(cont_cnt),   64'd0);
        check_output("satclr.contention", 64'(contention), 64'd0);

        // Asynchronous reset in the middle of a faulted transfer
        src[9] = 32'hDEAD_BEEF;
        apply_stimulus(24'h3, 1'b0);
        apply_stimulus(24'(1) << 9, 1'b0);
        check_output("pre_clr.bus_out",    64'(bus_out),    64'hDEAD_BEEF);
        check_output("pre_clr.contention", 64'(contention), 64'd1);
        #2;
        clr = 1'b1;
        #1;
        check_output("async.bus_out",    64'(bus_out),    64'h0);
        check_output("async.bus_valid",  64'(bus_valid),  64'h0);
        check_output("async.bus_sel",    64'(bus_sel),    64'h0);
        check_output("async.contention", 64'(contention), 64'h0);
        check_output("async.cont_cnt",   64'(cont_cnt),   64'h0);
        check_output("async.cont_cnt4",  64'(cont_cnt_s), 64'h0);
        #1;
        clr = 1'b0;
        model_reset();
        apply_stimulus(24'h0, 1'b0);
        check_model("post_clr_idle");
        apply_stimulus(24'(1) << 9, 1'b0);
        check_model("post_clr_drive");

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < N; i++) src[i] = $urandom;
            case ($urandom_range(0, 3))
                0: d = '0;
                1, 2: d = 24'(1) << $urandom_range(0, N - 1);
                default: begin
                    a = $urandom_range(0, N - 1);
                    b = (a + $urandom_range(1, N - 1)) % N;
                    d = (24'(1) << a) | (24'(1) << b);
                    if ($urandom_range(0, 1) == 1) d = d | (24'(1) << $urandom_range(0, N - 1));
                end
            endcase
            apply_stimulus(d, ($urandom_range(0, 7) == 0));
            check_model($sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
